// File: rtl/n_way_arb_mux_if.sv
// n_way_arb_mux_if: control, per-channel input and output handshake bundle for n_way_arb_mux
interface n_way_arb_mux_if #(
    parameter int WIDTH = 16,
    parameter int N = 4,
    parameter int SELW = 2
);
    logic clear;
    logic mode;
    logic [SELW-1:0] sel;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0] in_valid;
    logic [N-1:0] in_ready;
    logic [WIDTH-1:0] out_data;
    logic [SELW-1:0] out_chan;
    logic out_valid;
    logic out_ready;
    modport master (
        output clear, mode, sel, in_data, in_valid, out_ready,
        input in_ready, out_data, out_chan, out_valid
    );
    modport slave (
        input clear, mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/n_way_arb_mux.sv
// n_way_arb_mux: N-way registered mux, direct select or round-robin, valid/ready on every side
// Defining N_WAY_ARB_MUX_STATS_EN adds the saturating output-transfer counter port xfer_count
module n_way_arb_mux #(
    parameter int WIDTH = 16,
    parameter int N = 4,
    parameter int SELW = 2
) (
    input logic clk,
    input logic reset_n,
    n_way_arb_mux_if.slave bus
`ifdef N_WAY_ARB_MUX_STATS_EN
    ,
    output logic [15:0] xfer_count
`endif
);
    logic [2**SELW-1:0] valid_pad;
    logic [SELW-1:0] rr_ptr;
    logic [SELW-1:0] rr_gnt;
    logic [SELW-1:0] gnt;
    logic [WIDTH-1:0] sel_data;
    logic rr_hit;
    logic grant_valid;
    logic take;
    logic drain;
    // zero-extended valids make any select code >= N read as not valid
    assign valid_pad = (2**SELW)'(bus.in_valid);
    // lowest k wins, so the scan starts just after the last granted channel
    always_comb begin
        int j;
        rr_gnt = '0;
        rr_hit = 1'b0;
        j = 0;
        for (int k = N; k >= 1; k--) begin
            j = int'(rr_ptr) + k;
            j = (j >= N) ? j - N : j;
            if (valid_pad[SELW'(j)]) begin
                rr_hit = 1'b1;
                rr_gnt = SELW'(j);
            end
        end
    end
    assign gnt = bus.mode ? rr_gnt : bus.sel;
    assign grant_valid = bus.mode ? rr_hit : valid_pad[bus.sel];
    assign take = (~bus.out_valid | bus.out_ready) & ~bus.clear & grant_valid;
    assign drain = bus.out_valid & bus.out_ready;
    for (genvar i = 0; i < N; i++) begin : g_ready
        assign bus.in_ready[i] = take & (gnt == SELW'(i));
    end
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++)
            if (gnt == SELW'(i)) sel_data = bus.in_data[i*WIDTH +: WIDTH];
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data <= '0;
            bus.out_chan <= '0;
            rr_ptr <= SELW'(N - 1);
        end else if (bus.clear) begin
            bus.out_valid <= 1'b0;
            rr_ptr <= SELW'(N - 1);
        end else if (take) begin
            bus.out_valid <= 1'b1;
            bus.out_data <= sel_data;
            bus.out_chan <= gnt;
            rr_ptr <= gnt;
        end else if (drain) begin
            bus.out_valid <= 1'b0;
        end
    end
`ifdef N_WAY_ARB_MUX_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) xfer_count <= '0;
        else if (bus.clear) xfer_count <= '0;
        else if (drain && xfer_count != 16'hFFFF) xfer_count <= xfer_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_n_way_arb_mux.sv
// tb_n_way_arb_mux: directed checks of n_way_arb_mux (N=4 main instance, N=3 instance for select range)
module tb_n_way_arb_mux;
    logic clk = 1'b0;
    logic reset_n;
    int tests = 0;
    int failed = 0;
    n_way_arb_mux_if #(.WIDTH(16), .N(4), .SELW(2)) bus ();
    n_way_arb_mux_if #(.WIDTH(16), .N(3), .SELW(2)) bus3 ();
`ifdef N_WAY_ARB_MUX_STATS_EN
    logic [15:0] xfer_count;
    logic [15:0] xfer_count3;
`endif
    n_way_arb_mux #(.WIDTH(16), .N(4), .SELW(2)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
`ifdef N_WAY_ARB_MUX_STATS_EN
        ,
        .xfer_count(xfer_count)
`endif
    );
    n_way_arb_mux #(.WIDTH(16), .N(3), .SELW(2)) dut3 (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus3)
`ifdef N_WAY_ARB_MUX_STATS_EN
        ,
        .xfer_count(xfer_count3)
`endif
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    initial begin
        reset_n = 1'b0;
        bus.clear = 1'b0;
        bus.mode = 1'b0;
        bus.sel = '0;
        bus.in_data = '0;
        bus.in_valid = '0;
        bus.out_ready = 1'b0;
        bus3.clear = 1'b0;
        bus3.mode = 1'b0;
        bus3.sel = '0;
        bus3.in_data = '0;
        bus3.in_valid = '0;
        bus3.out_ready = 1'b0;
        #1;
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_out_data", 32'(bus.out_data), 32'd0);
        check("reset_out_chan", 32'(bus.out_chan), 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd0);
        tick(2);
        reset_n = 1'b1;
        // mode 0 basic
        bus.sel = 2'd2;
        bus.in_valid = 4'b0100;
        bus.in_data = {16'h3333, 16'hBEEF, 16'h1111, 16'h0000};
        bus.out_ready = 1'b1;
        #1;
        check("m0_in_ready", 32'(bus.in_ready), 32'h4);
        tick(1);
        check("m0_out_valid", 32'(bus.out_valid), 32'd1);
        check("m0_out_data", 32'(bus.out_data), 32'hBEEF);
        check("m0_out_chan", 32'(bus.out_chan), 32'd2);
        bus.in_valid = '0;
        tick(1);
        check("m0_drain_valid", 32'(bus.out_valid), 32'd0);
        check("m0_drain_data_hold", 32'(bus.out_data), 32'hBEEF);
        // mode 0 blocked selection
        bus.sel = 2'd1;
        bus.in_valid = 4'b1101;
        #1;
        check("m0_blocked_ready", 32'(bus.in_ready), 32'd0);
        tick(1);
        check("m0_blocked_valid", 32'(bus.out_valid), 32'd0);
        bus3.sel = 2'd3;
        bus3.in_valid = 3'b111;
        bus3.out_ready = 1'b1;
        #1;
        check("n3_sel3_ready", 32'(bus3.in_ready), 32'd0);
        bus3.sel = 2'd2;
        #1;
        check("n3_sel2_ready", 32'(bus3.in_ready), 32'h4);
        bus3.in_valid = '0;
        // round-robin fairness from reset
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        bus.mode = 1'b1;
        bus.in_valid = 4'b1111;
        bus.in_data = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
        bus.out_ready = 1'b1;
        #1;
        check("rr_first_ready", 32'(bus.in_ready), 32'h1);
        for (int k = 0; k < 6; k++) begin
            tick(1);
            check("rr_out_chan", 32'(bus.out_chan), 32'(k % 4));
            check("rr_out_data", 32'(bus.out_data), 32'hA000 + 32'(k % 4));
        end
        check("rr_out_valid", 32'(bus.out_valid), 32'd1);
        // backpressure
        bus.mode = 1'b0;
        bus.sel = 2'd0;
        bus.in_valid = 4'b0001;
        bus.in_data[15:0] = 16'h1234;
        tick(1);
        check("bp_load", 32'(bus.out_data), 32'h1234);
        bus.out_ready = 1'b0;
        bus.in_data[15:0] = 16'h5555;
        #1;
        check("bp_ready_now", 32'(bus.in_ready), 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick(1);
            check("bp_hold_data", 32'(bus.out_data), 32'h1234);
            check("bp_hold_ready", 32'(bus.in_ready), 32'd0);
        end
        check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        bus.sel = 2'd3;
        bus.in_valid = 4'b1000;
        bus.in_data[63:48] = 16'h3C3C;
        #1;
        check("bp_release_ready", 32'(bus.in_ready), 32'h8);
        tick(1);
        check("bp_refill_data", 32'(bus.out_data), 32'h3C3C);
        check("bp_refill_chan", 32'(bus.out_chan), 32'd3);
        check("bp_refill_valid", 32'(bus.out_valid), 32'd1);
        bus.sel = 2'd1;
        bus.in_valid = 4'b0010;
        bus.in_data[31:16] = 16'h7777;
        tick(1);
        check("pre_clear_chan", 32'(bus.out_chan), 32'd1);
        // clear mid-stream
        bus.out_ready = 1'b0;
        bus.clear = 1'b1;
        bus.mode = 1'b1;
        bus.in_valid = 4'b1010;
        #1;
        check("clear_ready", 32'(bus.in_ready), 32'd0);
        tick(1);
        check("clear_valid", 32'(bus.out_valid), 32'd0);
        check("clear_data_hold", 32'(bus.out_data), 32'h7777);
        bus.clear = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("post_clear_ready", 32'(bus.in_ready), 32'h2);
        tick(1);
        check("post_clear_chan", 32'(bus.out_chan), 32'd1);
        // asynchronous reset mid-stream
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_data", 32'(bus.out_data), 32'd0);
        check("async_rst_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_chan", 32'(bus.out_chan), 32'd0);
        #2;
        reset_n = 1'b1;
        #1;
        check("post_rst_ready", 32'(bus.in_ready), 32'h2);
        tick(1);
        check("post_rst_chan", 32'(bus.out_chan), 32'd1);
`ifdef N_WAY_ARB_MUX_STATS_EN
        reset_n = 1'b0;
        #1;
        check("stats_reset", 32'(xfer_count), 32'd0);
        reset_n = 1'b1;
        bus.mode = 1'b0;
        bus.sel = 2'd0;
        bus.in_valid = 4'b0001;
        bus.out_ready = 1'b1;
        tick(3);
        bus.in_valid = '0;
        tick(2);
        check("stats_three", 32'(xfer_count), 32'd3);
        bus.clear = 1'b1;
        tick(1);
        bus.clear = 1'b0;
        check("stats_clear", 32'(xfer_count), 32'd0);
        bus.in_valid = 4'b0001;
        tick(65540);
        check("stats_saturate", 32'(xfer_count), 32'hFFFF);
        bus.in_valid = '0;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
